// File: rtl/int_res_mem_ctrl_pkg.sv
// Shared types for the intermediate-result memory controller: access width,
// stored fixed-point format selector and its fractional-bit lookup.
package int_res_mem_ctrl_pkg;

   typedef enum logic {
      SINGLE_WIDTH = 1'b0,
      DOUBLE_WIDTH = 1'b1
   } DataWidth_t;

   typedef logic [1:0] FxFormatIntRes_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_HI = 2'd1,
      RD_HI = 2'd2
   } ctrl_state_t;

   localparam int COMP_FRAC = 16;

   // Fractional bits of the single-width stored format; double adds 16 more.
   function automatic int frac_bits(input FxFormatIntRes_t fmt);
      case (fmt)
         2'd0:    return 12;
         2'd1:    return 10;
         2'd2:    return 8;
         default: return 4;
      endcase
   endfunction

endpackage

// File: rtl/int_res_mem_ctrl_if.sv
// Compute-side read/write request bundle; master = compute datapath,
// slave = int_res_mem_ctrl.
interface int_res_mem_ctrl_if
   import int_res_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int COMP_W = 32
) ();

   logic                     rd_en;
   logic [ADDR_W-1:0]        rd_addr;
   DataWidth_t               rd_width;
   FxFormatIntRes_t          rd_format;
   logic                     rd_ready;
   logic signed [COMP_W-1:0] rd_data;
   logic                     rd_valid;

   logic                     wr_en;
   logic                     wr_chip_en;
   logic [ADDR_W-1:0]        wr_addr;
   DataWidth_t               wr_width;
   FxFormatIntRes_t          wr_format;
   logic signed [COMP_W-1:0] wr_data;
   logic                     wr_ready;

   modport master (
      output rd_en, rd_addr, rd_width, rd_format,
      output wr_en, wr_chip_en, wr_addr, wr_width, wr_format, wr_data,
      input  rd_ready, rd_data, rd_valid, wr_ready
   );

   modport slave (
      input  rd_en, rd_addr, rd_width, rd_format,
      input  wr_en, wr_chip_en, wr_addr, wr_width, wr_format, wr_data,
      output rd_ready, rd_data, rd_valid, wr_ready
   );

endinterface

// File: rtl/int_res_mem_ctrl_fx_cast.sv
// Combinational fixed-point casts between the compute format (Q.16) and the
// stored formats, in both directions, with a write-side saturation flag.
module int_res_fx_cast
   import int_res_mem_ctrl_pkg::*;
#(
   parameter int COMP_W  = 32,
   parameter int STORE_W = 16
) (
   input  DataWidth_t               wr_width,
   input  FxFormatIntRes_t          wr_format,
   input  logic signed [COMP_W-1:0] wr_data,
   output logic [COMP_W-1:0]        wr_word,
   output logic                     wr_sat,
   input  DataWidth_t               rd_width,
   input  FxFormatIntRes_t          rd_format,
   input  logic [COMP_W-1:0]        rd_word,
   output logic signed [COMP_W-1:0] rd_data
);

   localparam int WIDE_W = COMP_W + STORE_W;

   logic signed [WIDE_W-1:0] wd;
   int                       wf;
   int                       rf;

   function automatic logic signed [WIDE_W-1:0] round_shr(
      input logic signed [WIDE_W-1:0] v, input int sh);
      logic signed [WIDE_W-1:0] half;
      half = WIDE_W'(1) <<< (sh - 1);
      return (v + half) >>> sh;
   endfunction

   // Clamp to a signed 'bits'-wide range; ovf reports that clamping happened.
   function automatic logic signed [WIDE_W-1:0] saturate(
      input logic signed [WIDE_W-1:0] v, input int bits, output logic ovf);
      logic signed [WIDE_W-1:0] hi;
      logic signed [WIDE_W-1:0] lo;
      hi  = (WIDE_W'(1) <<< (bits - 1)) - WIDE_W'(1);
      lo  = ~hi;
      ovf = (v > hi) || (v < lo);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   always_comb begin
      wf      = frac_bits(wr_format);
      wd      = WIDE_W'(wr_data);
      wr_sat  = 1'b0;
      if (wr_width == DOUBLE_WIDTH)
         wr_word = COMP_W'(saturate(wd <<< wf, COMP_W, wr_sat));
      else
         wr_word = COMP_W'(saturate(round_shr(wd, COMP_FRAC - wf), STORE_W, wr_sat));
   end

   always_comb begin
      rf = frac_bits(rd_format);
      if (rd_width == DOUBLE_WIDTH)
         rd_data = $signed(rd_word) >>> rf;
      else
         rd_data = COMP_W'($signed(rd_word[STORE_W-1:0])) <<< (COMP_FRAC - rf);
   end

endmodule

// File: rtl/int_res_mem_ctrl.sv
// Intermediate-result SRAM controller: request FSM, bank drive and read
// pipeline. Optional saturation counter enabled by INT_RES_SAT_CNT_EN.
module int_res_mem_ctrl
   import int_res_mem_ctrl_pkg::*;
#(
   parameter int DEPTH   = 4096,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int COMP_W  = 32,
   parameter int STORE_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   int_res_mem_ctrl_if.slave  req,
   output logic               bank_en,
   output logic               bank_we,
   output logic               bank_chip_en,
   output logic [ADDR_W-1:0]  bank_addr,
   output logic [STORE_W-1:0] bank_wdata,
   input  logic [STORE_W-1:0] bank_rdata
`ifdef INT_RES_SAT_CNT_EN
   ,
   output logic [15:0]        sat_count
`endif
);

   ctrl_state_t              state;
   logic [ADDR_W-1:0]        addr_p0;
   logic [STORE_W-1:0]       hi_p0;
   logic                     chip_p0;
   DataWidth_t               rd_width_p0;
   FxFormatIntRes_t          rd_fmt_p0;
   logic                     lo_vld_p1;
   logic                     vld_p1;
   logic [STORE_W-1:0]       lo_p1;

   logic                     wr_acc;
   logic                     rd_acc;
   logic [COMP_W-1:0]        wr_word;
   logic                     wr_sat;
   logic [COMP_W-1:0]        rd_word;
   logic signed [COMP_W-1:0] rd_cast;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

   assign req.wr_ready = (state == IDLE);
   assign req.rd_ready = (state == IDLE) && !req.wr_en;
   assign wr_acc       = req.wr_en && req.wr_ready;
   assign rd_acc       = req.rd_en && req.rd_ready;

   assign rd_word = (rd_width_p0 == DOUBLE_WIDTH) ? {bank_rdata, lo_p1}
                                                  : {{(COMP_W-STORE_W){1'b0}}, bank_rdata};

   int_res_fx_cast #(.COMP_W(COMP_W), .STORE_W(STORE_W)) u_cast (
      .wr_width  (req.wr_width),
      .wr_format (req.wr_format),
      .wr_data   (req.wr_data),
      .wr_word   (wr_word),
      .wr_sat    (wr_sat),
      .rd_width  (rd_width_p0),
      .rd_format (rd_fmt_p0),
      .rd_word   (rd_word),
      .rd_data   (rd_cast)
   );

   // Stage p0: bank access is issued combinationally in the accept cycle.
   always_comb begin
      bank_en      = 1'b0;
      bank_we      = 1'b0;
      bank_chip_en = 1'b0;
      bank_addr    = '0;
      bank_wdata   = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (req.wr_en) begin
                  bank_en      = 1'b1;
                  bank_we      = 1'b1;
                  bank_chip_en = req.wr_chip_en;
                  bank_addr    = req.wr_addr;
                  bank_wdata   = wr_word[STORE_W-1:0];
               end else if (req.rd_en) begin
                  bank_en      = 1'b1;
                  bank_chip_en = 1'b1;
                  bank_addr    = req.rd_addr;
               end
            end
            WR_HI: begin
               bank_en      = 1'b1;
               bank_we      = 1'b1;
               bank_chip_en = chip_p0;
               bank_addr    = addr_p0;
               bank_wdata   = hi_p0;
            end
            RD_HI: begin
               bank_en      = 1'b1;
               bank_chip_en = 1'b1;
               bank_addr    = addr_p0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         lo_vld_p1    <= 1'b0;
         vld_p1       <= 1'b0;
         req.rd_valid <= 1'b0;
         req.rd_data  <= '0;
      end else begin
         req.rd_valid <= vld_p1;
         if (vld_p1)
            req.rd_data <= rd_cast;
         lo_vld_p1 <= 1'b0;
         vld_p1    <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_acc) begin
                  if (req.wr_width == DOUBLE_WIDTH)
                     state <= WR_HI;
               end else if (rd_acc) begin
                  if (req.rd_width == DOUBLE_WIDTH) begin
                     state     <= RD_HI;
                     lo_vld_p1 <= 1'b1;
                  end else begin
                     vld_p1 <= 1'b1;
                  end
               end
            end
            WR_HI: state <= IDLE;
            RD_HI: begin
               state  <= IDLE;
               vld_p1 <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stage p1: operands for the second half and the read cast are held here.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         addr_p0 <= next_addr(req.wr_addr);
         hi_p0   <= wr_word[COMP_W-1:STORE_W];
         chip_p0 <= req.wr_chip_en;
      end else if (rd_acc) begin
         addr_p0     <= next_addr(req.rd_addr);
         rd_width_p0 <= req.rd_width;
         rd_fmt_p0   <= req.rd_format;
      end
      if (lo_vld_p1)
         lo_p1 <= bank_rdata;
   end

`ifdef INT_RES_SAT_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         sat_count <= '0;
      else if (wr_acc && wr_sat && (sat_count != 16'hFFFF))
         sat_count <= sat_count + 16'd1;
   end
`else
   logic unused_sat;
   assign unused_sat = wr_sat;
`endif

   // Wrapping the high half to word 0 is legal but usually unintended.
   wrap_warn: assert property (@(posedge clk) disable iff (rst)
      !(((wr_acc && req.wr_width == DOUBLE_WIDTH) && (req.wr_addr == ADDR_W'(DEPTH - 1))) ||
        ((rd_acc && req.rd_width == DOUBLE_WIDTH) && (req.rd_addr == ADDR_W'(DEPTH - 1)))))
      else $warning("int_res_mem_ctrl: double access at last word wraps high half to address 0");

endmodule

// File: tb/tb_int_res_mem_ctrl.sv
// Bench for int_res_mem_ctrl: directed test-plan transactions then random
// traffic, checked every cycle against a transaction-level model.
module tb_int_res_mem_ctrl;
   import int_res_mem_ctrl_pkg::*;

   localparam int DEPTH  = 4096;
   localparam int ADDR_W = 12;
   localparam int COMP_W = 32;
   localparam int MAXC   = 4000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int_res_mem_ctrl_if #(.ADDR_W(ADDR_W), .COMP_W(COMP_W)) bus ();

   logic              bank_en, bank_we, bank_chip_en;
   logic [ADDR_W-1:0] bank_addr;
   logic [15:0]       bank_wdata;
   logic [15:0]       bank_rdata;
`ifdef INT_RES_SAT_CNT_EN
   logic [15:0]       sat_count;
`endif

   int_res_mem_ctrl #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (bus),
      .bank_en      (bank_en),
      .bank_we      (bank_we),
      .bank_chip_en (bank_chip_en),
      .bank_addr    (bank_addr),
      .bank_wdata   (bank_wdata),
      .bank_rdata   (bank_rdata)
`ifdef INT_RES_SAT_CNT_EN
      ,
      .sat_count    (sat_count)
`endif
   );

   // SRAM macro stand-in: one-cycle read latency.
   bit [15:0] sram [DEPTH];
   always @(posedge clk) begin
      if (bank_en) begin
         if (bank_we) sram[bank_addr] <= bank_wdata;
         else         bank_rdata      <= sram[bank_addr];
      end
   end

   typedef struct {
      bit r; bit re; int ra; bit rw; bit [1:0] rf;
      bit we; bit wc; int wa; bit ww; bit [1:0] wf; bit [31:0] wd;
   } stim_t;

   typedef struct packed {
      bit vld; bit we; bit chip; bit [ADDR_W-1:0] addr; bit [15:0] wdata;
   } bop_t;

   bit [15:0] mem [DEPTH];
   bop_t      sched [MAXC+8];
   bit        exp_v [MAXC+8];
   bit [31:0] exp_d [MAXC+8];
   int        cyc = 0;
   int        vectors = 0;
   int        miscompares = 0;
   bit        checking = 0;
`ifdef INT_RES_SAT_CNT_EN
   int        exp_sat = 0;
`endif

   logic        s_wrr, s_rdr, s_rdv, s_ben, s_bwe, s_bce;
   logic [31:0] s_rdd;
   logic [ADDR_W-1:0] s_badr;
   logic [15:0] s_bwd;

   function automatic int fr(input bit [1:0] f);
      int t[4] = '{12, 10, 8, 4};
      return t[f];
   endfunction

   // Compute Q.16 -> stored value (single: low 16 bits meaningful).
   function automatic bit [31:0] wcast(input bit dbl, input bit [1:0] f, input bit [31:0] d,
                                       output bit sat);
      longint v, r, mx, mn;
      v = longint'($signed(d));
      if (!dbl) begin
         r  = (v + (longint'(1) << (15 - fr(f)))) >>> (16 - fr(f));
         mx = 32767; mn = -32768;
      end else begin
         r  = v * (longint'(1) << fr(f));
         mx = (longint'(1) << 31) - 1; mn = -(longint'(1) << 31);
      end
      sat = 0;
      if (r > mx) begin r = mx; sat = 1; end
      else if (r < mn) begin r = mn; sat = 1; end
      return 32'(r);
   endfunction

   function automatic bit [31:0] rcast(input bit dbl, input bit [1:0] f, input bit [31:0] w);
      longint r;
      if (!dbl) r = longint'($signed(w[15:0])) * (longint'(1) << (16 - fr(f)));
      else      r = longint'($signed(w)) >>> fr(f);
      return 32'(r);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   task automatic step(input stim_t s);
      bop_t      eb;
      bit        busy, sat, inc;
      bit [31:0] cw;
      int        a1;
      @(negedge clk);
      rst            = s.r;
      bus.rd_en      = s.re;
      bus.rd_addr    = ADDR_W'(s.ra);
      bus.rd_width   = s.rw ? DOUBLE_WIDTH : SINGLE_WIDTH;
      bus.rd_format  = s.rf;
      bus.wr_en      = s.we;
      bus.wr_chip_en = s.wc;
      bus.wr_addr    = ADDR_W'(s.wa);
      bus.wr_width   = s.ww ? DOUBLE_WIDTH : SINGLE_WIDTH;
      bus.wr_format  = s.wf;
      bus.wr_data    = s.wd;
      #1;
      s_wrr = bus.wr_ready; s_rdr = bus.rd_ready; s_rdv = bus.rd_valid; s_rdd = bus.rd_data;
      s_ben = bank_en; s_bwe = bank_we; s_bce = bank_chip_en; s_badr = bank_addr; s_bwd = bank_wdata;

      busy = sched[cyc].vld;
      eb   = '0;
      inc  = 0;
      if (!s.r) begin
         if (busy) begin
            eb = sched[cyc];
            if (eb.we) mem[eb.addr] = eb.wdata;
         end else if (s.we) begin
            cw = wcast(s.ww, s.wf, s.wd, sat);
            inc = sat;
            eb.vld = 1; eb.we = 1; eb.chip = s.wc; eb.addr = ADDR_W'(s.wa); eb.wdata = cw[15:0];
            mem[s.wa] = cw[15:0];
            if (s.ww) begin
               sched[cyc+1].vld = 1; sched[cyc+1].we = 1; sched[cyc+1].chip = s.wc;
               sched[cyc+1].addr = ADDR_W'((s.wa + 1) % DEPTH); sched[cyc+1].wdata = cw[31:16];
            end
         end else if (s.re) begin
            eb.vld = 1; eb.chip = 1; eb.addr = ADDR_W'(s.ra);
            a1 = (s.ra + 1) % DEPTH;
            if (s.rw) begin
               sched[cyc+1].vld = 1; sched[cyc+1].we = 0; sched[cyc+1].chip = 1;
               sched[cyc+1].addr = ADDR_W'(a1); sched[cyc+1].wdata = '0;
               exp_v[cyc+3] = 1;
               exp_d[cyc+3] = rcast(1, s.rf, {mem[a1], mem[s.ra]});
            end else begin
               exp_v[cyc+2] = 1;
               exp_d[cyc+2] = rcast(0, s.rf, {16'h0, mem[s.ra]});
            end
         end
      end

      if (checking) begin
         chk("wr_ready", {31'b0, s_wrr}, {31'b0, !busy});
         chk("rd_ready", {31'b0, s_rdr}, {31'b0, !busy && !s.we});
         chk("rd_valid", {31'b0, s_rdv}, {31'b0, exp_v[cyc]});
         if (exp_v[cyc]) chk("rd_data", s_rdd, exp_d[cyc]);
         chk("bank_en", {31'b0, s_ben}, {31'b0, eb.vld});
         if (eb.vld) begin
            chk("bank_we", {31'b0, s_bwe}, {31'b0, eb.we});
            chk("bank_chip_en", {31'b0, s_bce}, {31'b0, eb.chip});
            chk("bank_addr", 32'(s_badr), 32'(eb.addr));
            if (eb.we) chk("bank_wdata", 32'(s_bwd), 32'(eb.wdata));
         end
`ifdef INT_RES_SAT_CNT_EN
         chk("sat_count", 32'(sat_count), 32'(exp_sat));
`endif
      end

      if (s.r) begin
         for (int k = 1; k <= 4; k++) begin
            sched[cyc+k] = '0;
            exp_v[cyc+k] = 0;
         end
      end
`ifdef INT_RES_SAT_CNT_EN
      if (s.r) exp_sat = 0;
      else if (inc && exp_sat != 16'hFFFF) exp_sat++;
`endif
      cyc++;
   endtask

   function automatic int pick_addr();
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) return DEPTH - 1;
      return r % 12;
   endfunction

   initial begin
      stim_t     s;
      bit        sat;
      bit [31:0] m;

      m = wcast(0, 2'd1, 32'h0001_8000, sat); chk("pin_wr_single", m, 32'h0000_0600);
      m = wcast(0, 2'd0, 32'h0040_0000, sat); chk("pin_wr_sat", m, 32'h0000_7FFF);
      m = wcast(0, 2'd1, 32'h0000_0020, sat); chk("pin_round", m, 32'h0000_0001);
      m = wcast(0, 2'd3, 32'hFFFF_8000, sat); chk("pin_wr_neg", m, 32'hFFFF_FFF8);
      m = wcast(1, 2'd2, 32'h0001_8000, sat); chk("pin_wr_double", m, 32'h0180_0000);
      m = rcast(1, 2'd2, 32'h0180_0000);      chk("pin_rd_double", m, 32'h0001_8000);
      m = rcast(0, 2'd1, 32'h0000_0600);      chk("pin_rd_single", m, 32'h0001_8000);

      s = idle(); s.r = 1;
      step(s);
      checking = 1;
      step(s);
      chk("rst_rd_valid", {31'b0, s_rdv}, 32'h0);
      chk("rst_rd_data", s_rdd, 32'h0);
      chk("rst_bank_en", {31'b0, s_ben}, 32'h0);
      chk("rst_bank_addr", 32'(s_badr), 32'h0);
      chk("rst_bank_wdata", 32'(s_bwd), 32'h0);

      s = idle(); s.we = 1; s.wc = 1; s.wa = 5; s.wf = 2'd1; s.wd = 32'h0001_8000;
      step(s);
      chk("t1_wdata", 32'(s_bwd), 32'h0600);
      chk("t1_addr", 32'(s_badr), 32'd5);
      s = idle(); s.re = 1; s.ra = 5; s.rf = 2'd1;
      step(s);
      step(idle());
      chk("t1_lat1_valid", {31'b0, s_rdv}, 32'h0);
      step(idle());
      chk("t1_lat2_valid", {31'b0, s_rdv}, 32'h1);
      chk("t1_lat2_data", s_rdd, 32'h0001_8000);

      s = idle(); s.we = 1; s.wc = 1; s.wa = 6; s.wf = 2'd0; s.wd = 32'h0040_0000;
      step(s);
      chk("t2_sat_wdata", 32'(s_bwd), 32'h7FFF);
      step(idle());
`ifdef INT_RES_SAT_CNT_EN
      chk("t2_sat_count", 32'(sat_count), 32'd1);
`endif

      s = idle(); s.we = 1; s.wc = 0; s.wa = 7; s.wf = 2'd1; s.wd = 32'h0000_0020;
      step(s);
      chk("t3_round", 32'(s_bwd), 32'h0001);
      chk("t3_chip_en", {31'b0, s_bce}, 32'h0);

      s = idle(); s.we = 1; s.wc = 1; s.wa = DEPTH - 1; s.ww = 1; s.wf = 2'd2; s.wd = 32'h0001_8000;
      step(s);
      chk("t4_lo_addr", 32'(s_badr), DEPTH - 1);
      chk("t4_lo_data", 32'(s_bwd), 32'h0000);
      step(idle());
      chk("t4_busy", {31'b0, s_wrr}, 32'h0);
      chk("t4_hi_addr", 32'(s_badr), 32'h0);
      chk("t4_hi_data", 32'(s_bwd), 32'h0180);
      step(idle());
      chk("t4_ready", {31'b0, s_wrr}, 32'h1);
      s = idle(); s.re = 1; s.ra = DEPTH - 1; s.rw = 1; s.rf = 2'd2;
      step(s);
      step(idle());
      step(idle());
      chk("t4_lat2_valid", {31'b0, s_rdv}, 32'h0);
      step(idle());
      chk("t4_lat3_valid", {31'b0, s_rdv}, 32'h1);
      chk("t4_lat3_data", s_rdd, 32'h0001_8000);

      s = idle(); s.we = 1; s.wc = 1; s.wa = 8; s.wf = 2'd1; s.wd = 32'h0002_4000;
      s.re = 1; s.ra = 5; s.rf = 2'd1;
      step(s);
      chk("t5_rd_ready", {31'b0, s_rdr}, 32'h0);
      chk("t5_wr_data", 32'(s_bwd), 32'h0900);
      s = idle(); s.re = 1; s.ra = 5; s.rf = 2'd1;
      step(s);
      chk("t5_rd_accept", {31'b0, s_rdr}, 32'h1);
      step(idle());
      step(idle());
      chk("t5_rd_data", s_rdd, 32'h0001_8000);

      s = idle(); s.re = 1; s.ra = DEPTH - 1; s.rw = 1; s.rf = 2'd2;
      step(s);
      s = idle(); s.r = 1;
      step(s);
      chk("t6_in_rd_hi", {31'b0, s_wrr}, 32'h0);
      step(idle());
      chk("t6_rd_ready", {31'b0, s_rdr}, 32'h1);
      chk("t6_no_valid_a", {31'b0, s_rdv}, 32'h0);
      step(idle());
      chk("t6_no_valid_b", {31'b0, s_rdv}, 32'h0);

      for (int i = 0; i < 1500; i++) begin
         s.r  = ($urandom_range(0, 149) == 0);
         s.re = ($urandom_range(0, 2) != 0);
         s.ra = pick_addr();
         s.rw = 1'($urandom_range(0, 1));
         s.rf = 2'($urandom_range(0, 3));
         s.we = ($urandom_range(0, 2) == 0);
         s.wc = 1'($urandom_range(0, 1));
         s.wa = pick_addr();
         s.ww = 1'($urandom_range(0, 1));
         s.wf = 2'($urandom_range(0, 3));
         s.wd = 32'($signed($urandom()) >>> $urandom_range(0, 24));
         step(s);
      end
      for (int i = 0; i < 4; i++) step(idle());

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/int_res_mem_ctrl.md
Name: int_res_mem_ctrl

Overview:
- Responder-side controller for intermediate-result storage.
- Accepts read and write requests from compute: enable, address, data width (single or double) and fixed-point format.
- Casts between the compute fixed-point format and the stored format, then drives one single-port 16-bit bank.
- Sits between the compute datapath and the intermediate-result SRAM macro.

Parameters:
- DEPTH, 4096, bank depth in 16-bit words.
- ADDR_W, $clog2(DEPTH), address width.
- COMP_W, 32, compute word width; signed, 16 fractional bits.
- STORE_W, 16, bank word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  word address
- rd_width  in  DataWidth_t  SINGLE_WIDTH / DOUBLE_WIDTH
- rd_format  in  FxFormatIntRes_t  stored format
- rd_ready  out  1  read accepted when rd_en && rd_ready
- rd_data  out  COMP_W  cast read data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- wr_en  in  1  write request
- wr_chip_en  in  1  passed to bank_chip_en on write cycles
- wr_addr  in  ADDR_W  word address
- wr_width  in  DataWidth_t  access width
- wr_format  in  FxFormatIntRes_t  target format
- wr_data  in  COMP_W  compute-format data
- wr_ready  out  1  write accepted when wr_en && wr_ready
- bank_en  out  1  bank access strobe
- bank_we  out  1  bank write
- bank_chip_en  out  1  bank chip enable
- bank_addr  out  ADDR_W  bank address
- bank_wdata  out  STORE_W  bank write data
- bank_rdata  in  STORE_W  bank read data; 1-cycle latency after bank_en && !bank_we

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - FSM = IDLE.
  - rd_valid = 0, rd_data = 0.
  - bank_en = bank_we = bank_chip_en = 0, bank_addr = 0, bank_wdata = 0.
- FSM states: IDLE, WR_HI, RD_HI.
  - wr_ready = (state == IDLE).
  - rd_ready = (state == IDLE) && !wr_en.
  - Write wins a simultaneous request; the read is stalled, not dropped by the controller.
- Single write:
  - Accept cycle drives bank_en = 1, bank_we = 1, bank_addr = wr_addr, bank_wdata = cast16.
  - Stays in IDLE.
- Double write:
  - Accept cycle writes the low half at addr.
  - Go to WR_HI; next cycle writes the high half at (addr+1) mod DEPTH, then return to IDLE.
  - Operands are captured at accept.
- Single read:
  - Cycle 0 issues the read.
  - Cycle 1 casts bank_rdata and registers it.
  - rd_valid pulses in cycle 2 (latency 2).
- Double read:
  - Cycle 0 issues lo; go to RD_HI.
  - Cycle 1 issues hi and captures lo.
  - Cycle 2 captures hi.
  - rd_valid pulses in cycle 3 (latency 3).
  - A new request may be accepted in cycle 2, so reads pipeline back-to-back.
- Address wrap: addr = DEPTH-1 with double width wraps the high half to 0. This is legal; a simulation-only assertion warns.
- Format table, F = frac bits:
  - fmt0: F = 12; fmt1: F = 10; fmt2: F = 8; fmt3: F = 4.
  - Single width stores F fractional bits.
  - Double width stores F+16 fractional bits.
- Write cast:
  - Single: shift right by 16-F with round-half-up (add 1<<(15-F) first), then saturate to signed 16 bits (0x7FFF / 0x8000).
  - Double: shift left by F, then saturate to signed 32 bits.
- Read cast:
  - Single: sign-extend, shift left by 16-F; no overflow is possible.
  - Double: arithmetic shift right by F, truncating toward -inf.
- Reset mid-operation:
  - The FSM aborts to IDLE.
  - An in-flight read produces no rd_valid.
  - A half-written double word is left as is.
- bank_chip_en = wr_chip_en on a write accept; it holds the captured value in WR_HI and is 1 on read cycles.

Optional Feature:
- Macro INT_RES_SAT_CNT_EN.
- When defined:
  - Adds output sat_count [15:0].
  - Increments once per write cast that saturated, and sticks at 0xFFFF.
  - Cleared by rst.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package Defines holds:
  - DataWidth_t (SINGLE_WIDTH, DOUBLE_WIDTH).
  - FxFormatIntRes_t (2-bit).
  - A frac-bits lookup function.
  - COMP_FRAC = 16.
- Sub-module int_res_fx_cast: combinational casts in both directions, plus a saturation flag output.
- The FSM and pipeline registers stay in int_res_mem_ctrl.

Test Plan:
- Single write fmt1, wr_data 0x0001_8000 at addr 5 -> bank_wdata 0x0600 at addr 5; read back -> rd_data 0x0001_8000 two cycles after accept.
- Single write fmt0, wr_data 0x0040_0000 -> bank_wdata 0x7FFF; sat_count = 1 when INT_RES_SAT_CNT_EN is defined.
- Rounding: fmt1, wr_data 0x0000_0020 -> bank_wdata 0x0001.
- Double write fmt2, wr_data 0x0001_8000 at addr DEPTH-1:
  - Expect 0x0000 at DEPTH-1, then 0x0180 at 0.
  - wr_ready low for 1 cycle.
  - Double read back -> rd_data 0x0001_8000 at latency 3.
- rd_en and wr_en asserted together -> write performed, rd_ready = 0; read accepted next cycle and returns correct data.
- rst asserted in RD_HI -> no rd_valid; state IDLE; rd_ready = 1 the next cycle.
